// File: rtl/reg_file_mp.sv
// Multi-port register file: NRD read ports, two write ports (port 1 has priority),
// write-first bypass, optional hardwired-zero r0 and optional registered reads.
module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int NRD      = 2,
   parameter int ZERO_REG = 1,
   parameter int READ_LAT = 0
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NRD*ADDR_W-1:0]   readReg,
   output logic [NRD*DATA_W-1:0]   readData,
   input  logic                    regWrite0,
   input  logic [ADDR_W-1:0]       writeReg0,
   input  logic [DATA_W-1:0]       writeData0,
   input  logic                    regWrite1,
   input  logic [ADDR_W-1:0]       writeReg1,
   input  logic [DATA_W-1:0]       writeData1
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0]     regs [DEPTH];
   logic                  wr0Ok;
   logic                  wr1Ok;
   logic [NRD*DATA_W-1:0] fwdData;

   // Effective enables: r0 writes dropped, port 0 loses same-address collisions,
   // and nothing is written or bypassed while reset is held.
   always_comb begin
      wr1Ok = rst_n && regWrite1 && !((ZERO_REG != 0) && (writeReg1 == '0));
      wr0Ok = rst_n && regWrite0 && !((ZERO_REG != 0) && (writeReg0 == '0))
              && !(wr1Ok && (writeReg0 == writeReg1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      end else begin
         if (wr0Ok) regs[writeReg0] <= writeData0;
         if (wr1Ok) regs[writeReg1] <= writeData1;
      end
   end

   // Post-write view of each addressed register; serves both the combinational
   // bypass and the next value of the registered read path.
   always_comb begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] v;
      a       = '0;
      v       = '0;
      fwdData = '0;
      for (int unsigned k = 0; k < NRD; k++) begin
         a = readReg[k*ADDR_W +: ADDR_W];
         v = regs[a];
         if (wr0Ok && (writeReg0 == a)) v = writeData0;
         if (wr1Ok && (writeReg1 == a)) v = writeData1;
         if ((ZERO_REG != 0) && (a == '0)) v = '0;
         fwdData[k*DATA_W +: DATA_W] = v;
      end
   end

   generate
      if (READ_LAT != 0) begin : gRegRead
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) readData <= '0;
            else        readData <= fwdData;
         end
      end else begin : gCombRead
         assign readData = fwdData;
      end
   endgenerate

endmodule
